// File: rtl/moore_seq101_detector.sv
// Moore FSM that flags the serial pattern 1-0-1 on x, with overlapping matches.
// The y output is decoded only from the state register, so it has no path from x.
module moore_seq101_detector (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       x,
  output logic       y,
  output logic [1:0] state
);

  localparam int unsigned STATE_W = 2;

  // Each state names the useful suffix seen so far: none, "1", "10", "101"
  localparam logic [STATE_W-1:0] S0 = 2'b00;
  localparam logic [STATE_W-1:0] S1 = 2'b01;
  localparam logic [STATE_W-1:0] S2 = 2'b10;
  localparam logic [STATE_W-1:0] S3 = 2'b11;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;

  // State register; reset is synchronous and wins over x
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; S3 on x=1 reuses the trailing '1' as a new prefix
  always_comb begin
    w_state_next = S0;
    case (r_state)
      S0:      w_state_next = x ? S1 : S0;
      S1:      w_state_next = x ? S1 : S2;
      S2:      w_state_next = x ? S3 : S0;
      S3:      w_state_next = x ? S1 : S2;
      default: w_state_next = S0;
    endcase
  end

  assign y     = (r_state == S3);
  assign state = r_state;

endmodule

// File: tb/tb_moore_seq101_detector.sv
// Self-checking bench for moore_seq101_detector: directed test-plan steps then
// randomized bits and resets, compared against a bit-history reference model.
module tb_moore_seq101_detector;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       x;
  logic       y;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: the last up-to-three bits received since the last reset
  logic [2:0] m_hist;
  int         m_len;
  logic       prev_y;

  always #5 clk = ~clk;

  moore_seq101_detector dut (
    .clk   (clk),
    .n_rst (n_rst),
    .x     (x),
    .y     (y),
    .state (state)
  );

  // Expected state = longest suffix of the history that is a prefix of "101"
  function automatic logic [1:0] model_state(input logic [2:0] h, input int len);
    if (len >= 3 && h == 3'b101)      return 2'd3;
    else if (len >= 2 && h[1:0] == 2'b10) return 2'd2;
    else if (len >= 1 && h[0])        return 2'd1;
    else                              return 2'd0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [1:0] exp_state;
    logic       exp_y;
    exp_state = model_state(m_hist, m_len);
    exp_y     = (m_len >= 3) && (m_hist == 3'b101);
    checks++;
    assert (state === exp_state) else begin
      errors++;
      $error("FAIL %s state observed=%b expected=%b", tag, state, exp_state);
    end
    checks++;
    assert (y === exp_y) else begin
      errors++;
      $error("FAIL %s y observed=%b expected=%b", tag, y, exp_y);
    end
    checks++;
    assert (!(prev_y === 1'b1 && y === 1'b1)) else begin
      errors++;
      $error("FAIL %s y_two_cycles observed=%b%b expected not 11", tag, prev_y, y);
    end
    prev_y = y;
  endtask

  // Apply inputs on the falling edge, update the model at the rising edge, sample 1ns later
  task automatic step(input logic r, input logic xv, input string tag);
    @(negedge clk);
    n_rst = r;
    x     = xv;
    @(posedge clk);
    if (!r) begin
      m_hist = 3'b000;
      m_len  = 0;
    end else begin
      m_hist = {m_hist[1:0], xv};
      if (m_len < 3) m_len++;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    logic xv;
    n_rst  = 1'b0;
    x      = 1'b0;
    m_hist = 3'b000;
    m_len  = 0;
    prev_y = 1'b0;

    // Reset held for two edges with x toggling, then released with x=0
    step(1'b0, 1'b1, "reset0");
    step(1'b0, 1'b0, "reset1");
    step(1'b1, 1'b0, "idle0");
    step(1'b1, 1'b0, "idle1");

    // Basic match 0,1,0,1 then 1
    step(1'b1, 1'b0, "basic0");
    step(1'b1, 1'b1, "basic1");
    step(1'b1, 1'b0, "basic2");
    step(1'b1, 1'b1, "basic3");
    step(1'b1, 1'b1, "basic4");

    // Overlap 1,0,1,0,1 from a clean start
    step(1'b0, 1'b0, "ovl_rst");
    step(1'b1, 1'b1, "ovl0");
    step(1'b1, 1'b0, "ovl1");
    step(1'b1, 1'b1, "ovl2");
    step(1'b1, 1'b0, "ovl3");
    step(1'b1, 1'b1, "ovl4");

    // Non-match path 1,1,0,0,1
    step(1'b0, 1'b0, "nm_rst");
    step(1'b1, 1'b1, "nm0");
    step(1'b1, 1'b1, "nm1");
    step(1'b1, 1'b0, "nm2");
    step(1'b1, 1'b0, "nm3");
    step(1'b1, 1'b1, "nm4");

    // Synchronous reset mid-pattern beats the completing '1'
    step(1'b0, 1'b0, "mid_rst0");
    step(1'b1, 1'b1, "mid0");
    step(1'b1, 1'b0, "mid1");
    step(1'b0, 1'b1, "mid_rst1");
    step(1'b1, 1'b1, "mid2");

    // Short n_rst glitch between edges while in S2 has no effect
    step(1'b1, 1'b0, "glitch_pre");
    #1 n_rst = 1'b0;
    #2 n_rst = 1'b1;
    check_outputs("glitch_hold");
    step(1'b1, 1'b1, "glitch_post");

    // Randomized bits with occasional resets
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 15) != 0);
      xv = 1'($urandom_range(0, 1));
      step(r, xv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq101_detector.md
Name: moore_seq101_detector

Overview:
- Two-bit-state Moore finite state machine that detects the serial bit pattern 1-0-1 on a single-bit input stream sampled once per clock. Overlapping matches are detected.
- Output y depends only on the current state. It asserts for exactly one cycle in the state reached after the final '1' of each match.
- Sits in the FSM logic examples as a standalone, fully synchronous control block. It exposes its state register for observability.

Parameters:
- None. State encoding is fixed: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- n_rst  input  1  synchronous active-low reset, sampled on rising clk edge
- x  input  1  serial data bit, sampled on rising clk edge
- y  output  1  detect flag; 1 only while in state S3
- state  output  2  current state register value (debug/observability); may be left unconnected

Behaviour:
- One clock; reset is synchronous and active-low.
  - n_rst=0 at a rising clk edge: state <= S0 regardless of x.
  - No asynchronous effect: state holds between edges even if n_rst falls mid-cycle.
- Reset values: state=S0, y=0.
- State meanings:
  - S0: idle, no useful prefix.
  - S1: last bit '1'.
  - S2: last bits '10'.
  - S3: last bits '101', match.
- Transitions on rising clk with n_rst=1 (next state for x=0 / x=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S1 (overlap: trailing '1' of a match starts a new prefix)
- Output decode:
  - y = (state == S3). Purely combinational from the state register, no dependence on x.
  - y must be glitch-free relative to the state register: decode from registered state only.
- Latency: the '1' completing a pattern, sampled at edge N, makes y=1 from edge N until edge N+1. y is never high for two consecutive cycles.
- State register is a 2-bit flop. Next-state logic is combinational, with a default branch that returns to S0; all four codes are legal, so the default is unreachable.
- Reset has priority over x at the same edge.
- Reset mid-pattern discards partial progress; a pattern spanning a reset is not detected.
- x is assumed synchronous to clk. No internal synchronizer.

Test Plan:
- Reset: hold n_rst=0 for 2 edges with x toggling -> state=00, y=0 throughout. Release -> state stays 00 while x=0.
- Basic match: after reset, x = 0,1,0,1 on successive edges -> state 00,01,10,11. y=1 for exactly the cycle after the 4th edge. Then x=1 -> state 01, y=0.
- Overlap: x = 1,0,1,0,1 -> y pulses after the 3rd and 5th edges (state 11 twice, with 10 between). Two detections total.
- Non-match paths: x = 1,1,0,0,1 -> states 01,01,10,00,01. y stays 0.
- Sync reset mid-pattern: x = 1,0 (state 10), then n_rst=0 with x=1 at the next edge -> state 00, not 11, y=0. With n_rst=1 and x=1 on the following edge -> state 01.
- Reset glitch between edges: pulse n_rst low for less than half a period, without spanning a rising edge, while in S2 -> state remains 10.
